// File: rtl/shared_reg_pkg.sv
// Shared definitions for the two-client shared register arbiter:
// ownership states, q_src encodings and the round-robin tie-break helper.
package shared_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_A    = 2'b01;
  localparam logic [1:0] SRC_B    = 2'b10;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // On a tie the client that did not own the register last time wins.
  function automatic state_t pick_owner(input logic a_req, input logic b_req,
                                        input logic last_owner);
    if (a_req && b_req) return (last_owner == OWNER_A) ? OWN_B : OWN_A;
    if (a_req)          return OWN_A;
    if (b_req)          return OWN_B;
    return IDLE;
  endfunction

endpackage

// File: rtl/rr_owner_fsm.sv
// Round-robin ownership FSM: decides which client owns the shared register,
// enforces the MAX_HOLD fairness limit and drives the registered grants.
module rr_owner_fsm
  import shared_reg_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       a_req,
  input  logic       b_req,
  output logic       a_gnt,
  output logic       b_gnt,
  output logic [1:0] state_dbg
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    case (state_q)
      IDLE: state_d = pick_owner(a_req, b_req, last_owner_q);
      OWN_A: begin
        if (!a_req) begin
          last_owner_d = OWNER_A;
          state_d      = pick_owner(1'b0, b_req, OWNER_A);
        end else if (b_req && hold_cnt_q == HOLD_LAST) begin
          last_owner_d = OWNER_A;
          state_d      = OWN_B;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      OWN_B: begin
        if (!b_req) begin
          last_owner_d = OWNER_B;
          state_d      = pick_owner(a_req, 1'b0, OWNER_B);
        end else if (a_req && hold_cnt_q == HOLD_LAST) begin
          last_owner_d = OWNER_B;
          state_d      = OWN_A;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) hold_cnt_d = 8'd0;
    // Clear drops ownership but keeps the round-robin history.
    if (clr) begin
      state_d      = IDLE;
      hold_cnt_d   = 8'd0;
      last_owner_d = last_owner_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_B;
      hold_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign a_gnt     = (state_q == OWN_A);
  assign b_gnt     = (state_q == OWN_B);
  assign state_dbg = state_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Single-driver shared register written by whichever of two clients currently
// owns it, with top-priority clear, update strobe and contention counter.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int                 WIDTH    = 8,
  parameter int                 MAX_HOLD = 4,
  parameter int                 CW       = 8,
  parameter logic [WIDTH-1:0]   RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_gnt,
  input  logic             b_req,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_gnt,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       q_src,
  output logic             upd,
  output logic [CW-1:0]    contention_cnt
);

  logic [1:0]       fsm_state;
  logic             wr_a, wr_b;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       q_src_q, q_src_d;
  logic             upd_q, upd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  rr_owner_fsm #(.MAX_HOLD(MAX_HOLD)) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .a_req     (a_req),
    .b_req     (b_req),
    .a_gnt     (a_gnt),
    .b_gnt     (b_gnt),
    .state_dbg (fsm_state)
  );

  // Only the current owner writes, and only while it still requests.
  assign wr_a = (fsm_state == OWN_A) && a_req;
  assign wr_b = (fsm_state == OWN_B) && b_req;

  always_comb begin
    q_d     = q_q;
    q_src_d = q_src_q;
    if (clr) begin
      q_d     = RST_VAL;
      q_src_d = SRC_NONE;
    end else if (wr_a) begin
      q_d     = a_data;
      q_src_d = SRC_A;
    end else if (wr_b) begin
      q_d     = b_data;
      q_src_d = SRC_B;
    end
    upd_d = (q_d != q_q) || (q_src_d != q_src_q);
    cnt_d = cnt_q;
    if (a_req && b_req && cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_VAL;
    else        q_q <= q_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_src_q <= SRC_NONE;
    else        q_src_q <= q_src_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upd_q <= 1'b0;
    else        upd_q <= upd_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q              = q_q;
  assign q_src          = q_src_q;
  assign upd            = upd_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: vector table plus hand sequences for async
// reset and long contention, all checked through an expected-value queue.
module tb_shared_reg_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, b_req, clr;
  logic [7:0] a_data, b_data;
  logic       a_gnt, b_gnt, upd;
  logic [7:0] q, contention_cnt;
  logic [1:0] q_src;

  typedef struct packed {
    logic       a_gnt;
    logic       b_gnt;
    logic [7:0] q;
    logic [1:0] src;
    logic       upd;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic       a_req;
    logic [7:0] a_data;
    logic       b_req;
    logic [7:0] b_data;
    logic       clr;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  shared_reg_arbiter #(
    .WIDTH(8), .MAX_HOLD(HOLD), .CW(8), .RST_VAL(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_data(b_data), .b_gnt(b_gnt),
    .clr(clr), .q(q), .q_src(q_src), .upd(upd),
    .contention_cnt(contention_cnt)
  );

  always @(negedge clk) begin
    n_checks++;
    if (a_gnt && b_gnt) begin
      n_fail++;
      $display("FAIL gnt_exclusive: a_gnt=%b b_gnt=%b, required not both 1", a_gnt, b_gnt);
    end
  end

  task automatic add(input logic ar, input logic [7:0] ad, input logic br,
                     input logic [7:0] bd, input logic c, input logic ea,
                     input logic eb, input logic [7:0] eq, input logic [1:0] es,
                     input logic eu, input logic [7:0] ec);
    vec_t v;
    v.a_req = ar; v.a_data = ad; v.b_req = br; v.b_data = bd; v.clr = c;
    v.exp = {ea, eb, eq, es, eu, ec};
    vecs.push_back(v);
  endtask

  task automatic check(input string name);
    exp_t e, act;
    act = {a_gnt, b_gnt, q, q_src, upd, contention_cnt};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b%b q=%h src=%b upd=%b cnt=%0d, required gnt=%b%b q=%h src=%b upd=%b cnt=%0d",
               name, act.a_gnt, act.b_gnt, act.q, act.src, act.upd, act.cnt,
               e.a_gnt, e.b_gnt, e.q, e.src, e.upd, e.cnt);
    end
  endtask

  task automatic drive(input logic ar, input logic [7:0] ad, input logic br,
                       input logic [7:0] bd, input logic c);
    a_req = ar; a_data = ad; b_req = br; b_data = bd; clr = c;
  endtask

  initial begin
    exp_t e;
    logic [7:0] prev_q;
    logic [1:0] prev_src;
    logic       own_b, writer_b;

    //   a_req a_data b_req b_data clr | a_gnt b_gnt q src upd cnt
    add(1, 8'h3C, 0, 8'h00, 0,  1, 0, 8'h00, 2'b00, 0, 8'd0);
    add(1, 8'h3C, 0, 8'h00, 0,  1, 0, 8'h3C, 2'b01, 1, 8'd0);
    add(1, 8'h3C, 0, 8'h00, 0,  1, 0, 8'h3C, 2'b01, 0, 8'd0);
    add(0, 8'h3C, 0, 8'h00, 0,  0, 0, 8'h3C, 2'b01, 0, 8'd0);
    add(1, 8'h11, 1, 8'h22, 0,  0, 1, 8'h3C, 2'b01, 0, 8'd1);
    add(1, 8'h11, 1, 8'h22, 0,  0, 1, 8'h22, 2'b10, 1, 8'd2);
    add(1, 8'h11, 0, 8'h22, 0,  1, 0, 8'h22, 2'b10, 0, 8'd2);
    add(1, 8'hFF, 0, 8'h22, 1,  0, 0, 8'h00, 2'b00, 1, 8'd2);
    add(1, 8'hFF, 0, 8'h22, 0,  1, 0, 8'h00, 2'b00, 0, 8'd2);
    add(1, 8'hFF, 0, 8'h22, 0,  1, 0, 8'hFF, 2'b01, 1, 8'd2);
    add(1, 8'hFF, 1, 8'h44, 0,  1, 0, 8'hFF, 2'b01, 0, 8'd3);
    add(1, 8'hFF, 1, 8'h44, 0,  1, 0, 8'hFF, 2'b01, 0, 8'd4);
    add(1, 8'hFF, 1, 8'h44, 0,  0, 1, 8'hFF, 2'b01, 0, 8'd5);
    add(1, 8'hFF, 1, 8'h44, 0,  0, 1, 8'h44, 2'b10, 1, 8'd6);
    add(0, 8'hFF, 0, 8'h44, 0,  0, 0, 8'h44, 2'b10, 0, 8'd6);
    add(1, 8'h77, 1, 8'h88, 1,  0, 0, 8'h00, 2'b00, 1, 8'd7);
    add(1, 8'h77, 1, 8'h88, 0,  1, 0, 8'h00, 2'b00, 0, 8'd8);
    add(0, 8'h77, 0, 8'h88, 0,  0, 0, 8'h00, 2'b00, 0, 8'd8);

    // Reset values.
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 8'h00, 0);
    #2;
    exp_q.push_back({1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'd0});
    check("reset_values");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a_req, vecs[i].a_data, vecs[i].b_req, vecs[i].b_data, vecs[i].clr);
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i));
    end

    // B gains ownership and writes, then reset hits mid-cycle.
    @(negedge clk);
    drive(0, 8'h00, 1, 8'h5A, 0);
    exp_q.push_back({1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 8'd8});
    @(posedge clk); #1; check("b_grant_before_reset");
    exp_q.push_back({1'b0, 1'b1, 8'h5A, 2'b10, 1'b1, 8'd8});
    @(posedge clk); #1; check("b_write_before_reset");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back({1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'd0});
    check("async_reset_immediate");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 8'd0});
    @(posedge clk); #1; check("b_regrant_after_reset");

    // Fresh reset, then both clients hold requests: A first, 4/4 alternation,
    // counter saturates at 0xFF.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 8'h00, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_q = 8'h00;
    prev_src = 2'b00;
    for (int i = 1; i <= 300; i++) begin
      drive(1, 8'hAA, 1, 8'h55, 0);
      own_b = (((i - 1) / HOLD) % 2) == 1;
      e.a_gnt = !own_b;
      e.b_gnt = own_b;
      if (i == 1) begin
        e.q = 8'h00; e.src = 2'b00;
      end else begin
        writer_b = (((i - 2) / HOLD) % 2) == 1;
        e.q   = writer_b ? 8'h55 : 8'hAA;
        e.src = writer_b ? 2'b10 : 2'b01;
      end
      e.upd = (e.q != prev_q) || (e.src != prev_src);
      e.cnt = (i > 255) ? 8'hFF : 8'(i);
      prev_q = e.q;
      prev_src = e.src;
      exp_q.push_back(e);
      @(posedge clk); #1;
      check($sformatf("contend_cycle%0d", i));
      @(negedge clk);
    end

    drive(0, 8'h00, 0, 8'h00, 0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
